// File: rtl/score_accumulator_pkg.sv
// Game constants shared by the judge, scoring and display blocks of the DDR datapath.
package score_accumulator_pkg;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_GREAT   = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  localparam logic [2:0] PTS_PERFECT_DEF = 3'd3;
  localparam logic [2:0] PTS_GREAT_DEF   = 3'd2;
  localparam logic [2:0] PTS_GOOD_DEF    = 3'd1;

  localparam int                  SCORE_W   = 6;
  localparam logic [SCORE_W-1:0]  SCORE_MAX = 6'd63;

endpackage

// File: rtl/six_bit_adder.sv
// Six-bit ripple-carry adder; exposes the full carry vector, bit 5 being the carry-out.
module six_bit_adder (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic [5:0] carry
);

  for (genvar i = 0; i < 6; i++) begin : g_bit
    logic c_in;
    if (i == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_rest
      assign c_in = carry[i-1];
    end
    assign sum[i]   = a[i] ^ b[i] ^ c_in;
    assign carry[i] = (a[i] & b[i]) | (c_in & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/score_accumulator.sv
// Per-player scoring stage: grade -> points with combo bonus, then a saturating 6-bit score.
module score_accumulator
  import score_accumulator_pkg::*;
#(
  parameter logic [2:0] PTS_PERFECT    = PTS_PERFECT_DEF,
  parameter logic [2:0] PTS_GREAT      = PTS_GREAT_DEF,
  parameter logic [2:0] PTS_GOOD       = PTS_GOOD_DEF,
  parameter int         COMBO_BONUS_AT = 4,
  parameter int         COMBO_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               hit_valid,
  input  logic [1:0]         hit_grade,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic               saturated,
  output logic               score_valid
);

  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
  localparam logic [COMBO_W-1:0] BONUS_AT  = COMBO_W'(COMBO_BONUS_AT);

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] sum,
                                                    input logic cout);
    return cout ? SCORE_MAX : sum;
  endfunction

  logic               flush;
  logic [2:0]         base;
  logic               bonus;
  logic [2:0]         pts_next;
  logic [COMBO_W-1:0] combo_next;
  logic [2:0]         pts_p1;
  logic               vld_p1;
  logic [SCORE_W-1:0] sum;
  logic [SCORE_W-1:0] carry;
  logic               carry_unused;

  assign flush = reset | clear;

  always_comb begin
    base = 3'd0;
    case (grade_e'(hit_grade))
      GRADE_GOOD:    base = PTS_GOOD;
      GRADE_GREAT:   base = PTS_GREAT;
      GRADE_PERFECT: base = PTS_PERFECT;
      default:       base = 3'd0;
    endcase
    bonus      = (grade_e'(hit_grade) != GRADE_MISS) && (combo >= BONUS_AT);
    pts_next   = base + {2'b00, bonus};
    combo_next = (grade_e'(hit_grade) == GRADE_MISS) ? '0
               : (combo == COMBO_MAX)                ? combo
               :                                       combo + 1'b1;
  end

  six_bit_adder u_add (
    .a     (score),
    .b     ({3'b000, pts_p1}),
    .cin   (1'b0),
    .sum   (sum),
    .carry (carry)
  );

  // Only the carry-out matters; the internal ripple carries are deliberately unused.
  assign carry_unused = ^carry[SCORE_W-2:0];

  always_ff @(posedge clk) begin
    if (flush) begin
      pts_p1      <= '0;
      vld_p1      <= 1'b0;
      combo       <= '0;
      score       <= '0;
      saturated   <= 1'b0;
      score_valid <= 1'b0;
    end else begin
      // Stage 1: grade to points, combo update
      vld_p1 <= hit_valid;
      if (hit_valid) begin
        pts_p1 <= pts_next;
        combo  <= combo_next;
      end
      // Stage 2: saturating accumulate against the freshest registered score
      score_valid <= vld_p1;
      if (vld_p1) begin
        score     <= sat_score(sum, carry[SCORE_W-1]);
        saturated <= saturated | carry[SCORE_W-1];
      end
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator with hand-computed expected scores and combos.
module tb_score_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       hit_valid;
  logic [1:0] hit_grade;
  logic [5:0] score;
  logic [3:0] combo;
  logic       saturated;
  logic       score_valid;

  int n_cmp = 0;
  int n_mis = 0;
  int sv_count = 0;
  int sv_base;

  always #5 clk = ~clk;

  score_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .hit_valid   (hit_valid),
    .hit_grade   (hit_grade),
    .score       (score),
    .combo       (combo),
    .saturated   (saturated),
    .score_valid (score_valid)
  );

  always @(negedge clk) if (score_valid) sv_count <= sv_count + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int good_exp [5] = '{0, 1, 2, 3, 4};

  initial begin
    reset = 1'b1; clear = 1'b0; hit_valid = 1'b0; hit_grade = 2'd0;

    // Reset with hits toggling: all dropped
    hit_valid = 1'b1; hit_grade = 2'd3; tick();
    hit_valid = 1'b0; tick();
    hit_valid = 1'b1; tick();
    reset = 1'b0; hit_valid = 1'b0; hit_grade = 2'd3;
    check_eq("rst_score", score, 0);
    check_eq("rst_combo", combo, 0);
    check_eq("rst_sat", saturated, 0);
    check_eq("rst_sv", score_valid, 0);
    tick(); tick(); tick();
    check_eq("rst_no_pulse", sv_count, 0);
    check_eq("idle_score", score, 0);

    // Single PERFECT
    hit_valid = 1'b1; hit_grade = 2'd3; tick();
    hit_valid = 1'b0; hit_grade = 2'd0;
    check_eq("perf_combo", combo, 1);
    check_eq("perf_sv_early", score_valid, 0);
    tick();
    check_eq("perf_score", score, 3);
    check_eq("perf_sv", score_valid, 1);
    tick();
    check_eq("perf_sv_once", score_valid, 0);

    // Five back-to-back GOOD from a cleared state: pts 1,1,1,1,2
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("clr_score", score, 0);
    sv_base = sv_count;
    good_exp = '{1, 2, 3, 4, 6};
    for (int i = 0; i < 6; i++) begin
      hit_valid = (i < 5); hit_grade = 2'd1;
      tick();
      if (i >= 1) begin
        check_eq($sformatf("good_score%0d", i), score, good_exp[i-1]);
        check_eq($sformatf("good_sv%0d", i), score_valid, 1);
      end
    end
    hit_valid = 1'b0;
    check_eq("good_combo", combo, 5);
    tick();
    check_eq("good_pulses", sv_count - sv_base, 5);

    // MISS resets combo, score unchanged, still pulses
    hit_valid = 1'b1; hit_grade = 2'd0; tick();
    hit_valid = 1'b0;
    check_eq("miss_combo", combo, 0);
    tick();
    check_eq("miss_score", score, 6);
    check_eq("miss_sv", score_valid, 1);
    tick();
    check_eq("miss_pulses", sv_count - sv_base, 6);

    // 18 consecutive PERFECT from clear: 60 after hit 16, saturate on hit 17
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      hit_valid = 1'b1; hit_grade = 2'd3;
      tick();
      if (i == 5)  check_eq("perf4_score", score, 12);
      if (i == 17) begin
        check_eq("perf16_score", score, 60);
        check_eq("perf16_sat", saturated, 0);
      end
      if (i == 18) begin
        check_eq("perf17_score", score, 63);
        check_eq("perf17_sat", saturated, 1);
      end
    end
    hit_valid = 1'b0;
    tick();
    check_eq("perf18_score", score, 63);
    check_eq("perf18_sat", saturated, 1);
    check_eq("perf18_combo", combo, 15);
    tick();
    check_eq("sat_sticky", saturated, 1);

    // clear on the same edge as a hit
    sv_base = sv_count;
    clear = 1'b1; hit_valid = 1'b1; hit_grade = 2'd3; tick();
    clear = 1'b0; hit_valid = 1'b0;
    check_eq("clrhit_score", score, 0);
    check_eq("clrhit_combo", combo, 0);
    check_eq("clrhit_sat", saturated, 0);
    tick(); tick(); tick();
    check_eq("clrhit_pulses", sv_count - sv_base, 0);
    check_eq("clrhit_score2", score, 0);

    // clear one cycle after a hit flushes stage 1
    hit_valid = 1'b1; hit_grade = 2'd2; tick();
    hit_valid = 1'b0;
    check_eq("flush_combo_pre", combo, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    sv_base = sv_count;
    tick(); tick(); tick();
    check_eq("flush_pulses", sv_count - sv_base, 0);
    check_eq("flush_score", score, 0);
    check_eq("flush_combo", combo, 0);
    check_eq("flush_sat", saturated, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
